// File: rtl/bpsk_tx_pkg.sv
// bpsk_tx_pkg
//   Shared definitions for the BPSK transmit path: controller FSM state
//   encoding, the word-length derivation, the even-parity helper and the
//   default preamble byte (also used by the receiver side).
package bpsk_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } tx_state_t;

  localparam logic [7:0]  DEFAULT_PREAMBLE = 8'hAA;

  // Widest byte the parity helper accepts; narrower data is zero-extended,
  // which leaves the XOR reduction unchanged.
  localparam int unsigned PAR_MAX_W = 32;

  // Clocks needed to modulate one full word.
  function automatic int unsigned word_cycles(input int unsigned word_width,
                                              input int unsigned samples_per_bit);
    return word_width * samples_per_bit;
  endfunction

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/bpsk_tx_if.sv
// bpsk_tx_if
//   Bundles the byte-source handshake, frame control and modulator drive
//   signals of the BPSK transmit controller.
//   master : byte source / frame requester side (drives start, frame_len,
//            s_data, s_valid; observes everything else)
//   slave  : controller side (bpsk_tx_controller)
interface bpsk_tx_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8
);
  localparam int unsigned WORD_WIDTH = DATA_WIDTH + 1;

  logic                  start;
  logic [LEN_WIDTH-1:0]  frame_len;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic                  mod_en;
  logic [WORD_WIDTH-1:0] mod_in;
  logic                  mod_load;
  logic                  busy;
  logic                  done;
  logic                  underrun;

  modport master (
    output start, frame_len, s_data, s_valid,
    input  s_ready, mod_en, mod_in, mod_load, busy, done, underrun
  );

  modport slave (
    input  start, frame_len, s_data, s_valid,
    output s_ready, mod_en, mod_in, mod_load, busy, done, underrun
  );
endinterface

// File: rtl/bpsk_tx_controller_timer.sv
// bpsk_word_timer
//   Free-running modulo-WORD_CYCLES counter marking modulation word slots.
//   clk      : system clock
//   arst     : synchronous active-high reset
//   clr      : hold the count at zero (next word starts at count 0)
//   count    : current position inside the word, 0..WORD_CYCLES-1
//   boundary : high in the last cycle of a word
module bpsk_word_timer
  import bpsk_tx_pkg::*;
#(
  parameter int unsigned WORD_CYCLES = 2304,
  localparam int unsigned CNT_W      = $clog2(WORD_CYCLES)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             boundary
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             boundary_s;

  // Next count: clear, wrap at the word boundary, otherwise increment.
  always_comb begin
    boundary_s = (count_q == CNT_W'(WORD_CYCLES - 1));
    if (clr) begin
      count_d = '0;
    end else if (boundary_s) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (arst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign boundary = boundary_s;

endmodule

// File: rtl/bpsk_tx_controller.sv
// bpsk_tx_controller
//   Frame sequencer in front of the 9-bit-word BPSK modulator. Sends
//   PREAMBLE_LEN preamble words, then frame_len payload bytes fetched over a
//   valid/ready handshake, each extended with an even-parity MSB and held for
//   exactly one modulation interval, with no gaps between words.
//   clk  : system clock
//   arst : synchronous active-high reset
//   bus  : slave modport carrying start/frame_len, the s_* byte handshake,
//          mod_en/mod_in/mod_load to the modulator and busy/done/underrun.
module bpsk_tx_controller
  import bpsk_tx_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH      = 8,
  parameter int unsigned           WORD_WIDTH      = DATA_WIDTH + 1,
  parameter int unsigned           SAMPLES_PER_BIT = 256,
  parameter logic [DATA_WIDTH-1:0] PREAMBLE        = DATA_WIDTH'(DEFAULT_PREAMBLE),
  parameter int unsigned           PREAMBLE_LEN    = 2,
  parameter int unsigned           LEN_WIDTH       = 8
) (
  input  logic    clk,
  input  logic    arst,
  bpsk_tx_if.slave bus
);

  localparam int unsigned           WORD_CYCLES = word_cycles(WORD_WIDTH, SAMPLES_PER_BIT);
  localparam int unsigned           CNT_W       = $clog2(WORD_CYCLES);
  localparam logic [3:0]            PRE_LAST    = 4'(PREAMBLE_LEN - 1);
  localparam logic [WORD_WIDTH-1:0] PRE_WORD    = {even_parity(PAR_MAX_W'(PREAMBLE)), PREAMBLE};

  tx_state_t             state_q,    state_d;
  logic [3:0]            pre_cnt_q,  pre_cnt_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  mod_en_q,   mod_en_d;
  logic [WORD_WIDTH-1:0] mod_in_q,   mod_in_d;
  logic                  mod_load_q, mod_load_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;
  logic                  underrun_q, underrun_d;
  logic                  s_ready_q,  s_ready_d;

  logic                  timer_clr_s;
  logic [CNT_W-1:0]      count_s;
  logic                  boundary_s;
  logic                  near_boundary_s;
  logic                  fetch_s;
  logic                  finish_s;
  logic [WORD_WIDTH-1:0] data_word_s;

  bpsk_word_timer #(
    .WORD_CYCLES (WORD_CYCLES)
  ) u_timer (
    .clk      (clk),
    .arst     (arst),
    .clr      (timer_clr_s),
    .count    (count_s),
    .boundary (boundary_s)
  );

  // Next state, word sequencing and registered-output values.
  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    remaining_d = remaining_q;
    mod_en_d    = mod_en_q;
    mod_in_d    = mod_in_q;
    mod_load_d  = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    underrun_d  = underrun_q;
    s_ready_d   = 1'b0;
    timer_clr_s = 1'b0;
    fetch_s     = 1'b0;
    finish_s    = 1'b0;
    data_word_s = {even_parity(PAR_MAX_W'(bus.s_data)), bus.s_data};
    // s_ready is registered, so it is raised one cycle ahead of the boundary
    // of a word that will be followed by a payload word.
    near_boundary_s = (count_s == CNT_W'(WORD_CYCLES - 2));

    case (state_q)
      ST_IDLE: begin
        timer_clr_s = 1'b1;
        if (bus.start) begin
          remaining_d = bus.frame_len;
          pre_cnt_d   = 4'd0;
          underrun_d  = 1'b0;
          mod_en_d    = 1'b1;
          mod_in_d    = PRE_WORD;
          mod_load_d  = 1'b1;
          busy_d      = 1'b1;
          state_d     = ST_PRE;
        end else begin
          mod_en_d = 1'b0;
          mod_in_d = '0;
          busy_d   = 1'b0;
        end
      end
      ST_PRE: begin
        if (boundary_s) begin
          if (pre_cnt_q == PRE_LAST) begin
            if (remaining_q == '0) begin
              finish_s = 1'b1;
            end else begin
              fetch_s = 1'b1;
            end
          end else begin
            pre_cnt_d  = pre_cnt_q + 4'd1;
            mod_load_d = 1'b1;
          end
        end else begin
          s_ready_d = near_boundary_s && (pre_cnt_q == PRE_LAST) && (remaining_q != '0);
        end
      end
      ST_DATA: begin
        if (boundary_s) begin
          if (remaining_q == '0) begin
            finish_s = 1'b1;
          end else begin
            fetch_s = 1'b1;
          end
        end else begin
          s_ready_d = near_boundary_s && (remaining_q != '0);
        end
      end
      ST_DONE: begin
        timer_clr_s = 1'b1;
        mod_en_d    = 1'b0;
        mod_in_d    = '0;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
      default: begin
        timer_clr_s = 1'b1;
        mod_en_d    = 1'b0;
        mod_in_d    = '0;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    if (finish_s) begin
      mod_en_d = 1'b0;
      mod_in_d = '0;
      busy_d   = 1'b0;
      done_d   = 1'b1;
      state_d  = ST_DONE;
    end else if (fetch_s) begin
      if (bus.s_valid) begin
        mod_in_d    = data_word_s;
        mod_load_d  = 1'b1;
        remaining_d = remaining_q - LEN_WIDTH'(1);
        state_d     = ST_DATA;
      end else begin
        // Byte was due but the source had nothing: abort without done.
        underrun_d = 1'b1;
        mod_en_d   = 1'b0;
        mod_in_d   = '0;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
    end else begin
      state_d = state_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q     <= ST_IDLE;
      pre_cnt_q   <= '0;
      remaining_q <= '0;
      mod_en_q    <= 1'b0;
      mod_in_q    <= '0;
      mod_load_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      s_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      remaining_q <= remaining_d;
      mod_en_q    <= mod_en_d;
      mod_in_q    <= mod_in_d;
      mod_load_q  <= mod_load_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
      s_ready_q   <= s_ready_d;
    end
  end

  assign bus.s_ready  = s_ready_q;
  assign bus.mod_en   = mod_en_q;
  assign bus.mod_in   = mod_in_q;
  assign bus.mod_load = mod_load_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.underrun = underrun_q;

endmodule

// File: tb/tb_bpsk_tx_controller.sv
// tb_bpsk_tx_controller
//   Scoreboard bench: stimulus pushes expected modulator words and mod_en run
//   lengths; a negedge monitor pops and compares them as the DUT presents
//   them. SAMPLES_PER_BIT=4 gives 36-cycle words, PREAMBLE_LEN=2.
module tb_bpsk_tx_controller;

  logic clk;
  logic arst;

  bpsk_tx_if #(.DATA_WIDTH(8), .LEN_WIDTH(8)) bus ();

  bpsk_tx_controller #(
    .DATA_WIDTH      (8),
    .WORD_WIDTH      (9),
    .SAMPLES_PER_BIT (4),
    .PREAMBLE        (8'hAA),
    .PREAMBLE_LEN    (2),
    .LEN_WIDTH       (8)
  ) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] exp_words[$];
  int         exp_len[$];
  logic [7:0] src_q[$];

  int         done_cnt = 0;
  int         srdy_cnt = 0;
  int         load_cnt = 0;
  int         run      = 0;
  logic       prev_en  = 1'b0;
  logic [8:0] prev_in  = 9'h000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Byte source: present the queue head; pop on a completed handshake.
  always @(negedge clk) begin
    if (src_q.size() > 0) begin
      bus.s_valid = 1'b1;
      bus.s_data  = src_q[0];
    end else begin
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;
    end
  end

  always @(posedge clk) begin
    logic [7:0] popped;
    if (bus.s_ready === 1'b1 && bus.s_valid === 1'b1 && src_q.size() > 0) begin
      popped = src_q.pop_front();
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic [8:0] w;
    int         l;
    if (bus.mod_load === 1'b1) begin
      load_cnt++;
      if (exp_words.size() == 0) begin
        check("unexpected_load", 32'(bus.mod_in), 32'h1FF);
      end else begin
        w = exp_words.pop_front();
        check("mod_in", 32'(bus.mod_in), 32'(w));
      end
    end else if (bus.mod_en === 1'b1) begin
      check("mod_in_hold", 32'(bus.mod_in), 32'(prev_in));
    end
    if (bus.mod_en === 1'b1) begin
      run++;
    end else if (prev_en) begin
      l = (exp_len.size() == 0) ? -1 : exp_len.pop_front();
      check("mod_en_len", 32'(run), 32'(l));
      run = 0;
    end
    if (bus.mod_en === 1'b0) check("mod_in_zero", 32'(bus.mod_in), 32'd0);
    if (bus.done === 1'b1) begin
      done_cnt++;
      check("done_after_en", {30'd0, prev_en, bus.mod_en}, 32'd2);
    end
    if (bus.s_ready === 1'b1) srdy_cnt++;
    prev_en = (bus.mod_en === 1'b1);
    prev_in = bus.mod_in;
  end

  task automatic check_zero(input string name);
    check(name, 32'({bus.s_ready, bus.mod_en, bus.mod_in, bus.mod_load,
                     bus.busy, bus.done, bus.underrun}), 32'd0);
  endtask

  task automatic push_pre();
    exp_words.push_back(9'h0AA);
    exp_words.push_back(9'h0AA);
  endtask

  // Pulse start for one edge; the first preamble word must appear right after.
  task automatic start_frame(input logic [7:0] len);
    bus.frame_len = len;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_load", 32'(bus.mod_load), 32'd1);
    check("start_busy", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_idle();
    int i = 0;
    while (bus.busy === 1'b1 && i < 1000) begin
      @(negedge clk);
      i++;
    end
    check("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, s0, l0, i;

    // 1. Reset held with start high: nothing starts until arst falls.
    arst          = 1'b1;
    bus.start     = 1'b1;
    bus.frame_len = 8'd0;
    bus.s_valid   = 1'b0;
    bus.s_data    = 8'h00;
    repeat (3) begin
      @(negedge clk);
      check_zero("reset_outputs");
    end
    push_pre();
    exp_len.push_back(72);
    arst = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    check("post_reset_load", 32'(bus.mod_load), 32'd1);
    check("post_reset_busy", 32'(bus.busy), 32'd1);
    wait_idle();
    @(negedge clk);

    // 2. Three bytes, source always valid; frame_len changed after start.
    d0 = done_cnt; s0 = srdy_cnt; l0 = load_cnt;
    push_pre();
    exp_words.push_back(9'h101);
    exp_words.push_back(9'h102);
    exp_words.push_back(9'h003);
    exp_len.push_back(180);
    src_q = '{8'h01, 8'h02, 8'h03};
    @(negedge clk);
    start_frame(8'd3);
    bus.frame_len = 8'd7;
    wait_idle();
    @(negedge clk);
    check("t2_s_ready_pulses", 32'(srdy_cnt - s0), 32'd3);
    check("t2_mod_load_pulses", 32'(load_cnt - l0), 32'd5);
    check("t2_done_pulses", 32'(done_cnt - d0), 32'd1);

    // 3. Underrun at the second byte, then a new start clears underrun.
    d0 = done_cnt;
    push_pre();
    exp_words.push_back(9'h005);
    exp_len.push_back(108);
    src_q = '{8'h05};
    @(negedge clk);
    start_frame(8'd2);
    wait_idle();
    check("t3_underrun", 32'(bus.underrun), 32'd1);
    check("t3_mod_en", 32'(bus.mod_en), 32'd0);
    @(negedge clk);
    check("t3_no_done", 32'(done_cnt - d0), 32'd0);
    check("t3_underrun_sticky", 32'(bus.underrun), 32'd1);
    push_pre();
    exp_len.push_back(72);
    start_frame(8'd0);
    check("t3_underrun_cleared", 32'(bus.underrun), 32'd0);
    wait_idle();
    @(negedge clk);

    // 4. Empty payload: preamble only, no s_ready.
    d0 = done_cnt; s0 = srdy_cnt;
    push_pre();
    exp_len.push_back(72);
    start_frame(8'd0);
    wait_idle();
    @(negedge clk);
    check("t4_no_s_ready", 32'(srdy_cnt - s0), 32'd0);
    check("t4_done", 32'(done_cnt - d0), 32'd1);

    // 5. start mid-frame and during DONE are ignored; one cycle later accepted.
    push_pre();
    exp_words.push_back(9'h107);
    exp_len.push_back(108);
    src_q = '{8'h07};
    @(negedge clk);
    start_frame(8'd1);
    repeat (50) @(negedge clk);
    bus.start     = 1'b1;
    bus.frame_len = 8'd9;
    @(negedge clk);
    bus.start = 1'b0;
    check("t5_busy_after_mid_start", 32'(bus.busy), 32'd1);
    i = 0;
    while (bus.done !== 1'b1 && i < 1000) begin
      @(negedge clk);
      i++;
    end
    check("t5_done_seen", 32'(bus.done), 32'd1);
    push_pre();
    exp_len.push_back(72);
    bus.frame_len = 8'd0;
    bus.start     = 1'b1;
    @(negedge clk);
    check("t5_done_start_ignored_busy", 32'(bus.busy), 32'd0);
    check("t5_done_start_ignored_load", 32'(bus.mod_load), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    check("t5_restart_load", 32'(bus.mod_load), 32'd1);
    check("t5_restart_busy", 32'(bus.busy), 32'd1);
    wait_idle();
    @(negedge clk);

    // 6. Reset mid-payload word, then a clean frame.
    push_pre();
    exp_words.push_back(9'h113);
    src_q = '{8'h13, 8'h22};
    @(negedge clk);
    start_frame(8'd2);
    repeat (72) @(negedge clk);
    check("t6_first_payload_load", 32'(bus.mod_load), 32'd1);
    repeat (10) @(negedge clk);
    exp_len.push_back(83);
    d0 = done_cnt;
    arst = 1'b1;
    @(negedge clk);
    check_zero("t6_reset_outputs");
    arst = 1'b0;
    src_q.delete();
    @(negedge clk);
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    push_pre();
    exp_words.push_back(9'h180);
    exp_len.push_back(108);
    src_q = '{8'h80};
    @(negedge clk);
    start_frame(8'd1);
    wait_idle();
    @(negedge clk);
    check("t6_clean_done", 32'(done_cnt - d0), 32'd1);

    @(negedge clk);
    check("words_left", 32'(exp_words.size()), 32'd0);
    check("runs_left", 32'(exp_len.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
